// File: rtl/seq_pkg.sv
// Shared types and constants for the program run controller.
package seq_pkg;

  localparam int PC_W = 10;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam pc_t PROG_BASE [4] = '{10'd0, 10'd256, 10'd512, 10'd768};

endpackage

// File: rtl/prog_sequencer_run_counter.sv
// RUN-cycle counter with clear, enable and a compare against the watchdog limit.
module run_counter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_timeout
);

  logic [CNT_W-1:0] r_count;

  // Saturating count so the value can never wrap even at the largest limit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count   = r_count;
  assign o_timeout = (r_count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/prog_sequencer.sv
// Run controller: Start/Ack handshake, PC base load, fetch gating, halt/watchdog stop.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int NUM_PROGS  = 3,
  parameter int PROG_BASE0 = int'(PROG_BASE[0]),
  parameter int PROG_BASE1 = int'(PROG_BASE[1]),
  parameter int PROG_BASE2 = int'(PROG_BASE[2]),
  parameter int PROG_BASE3 = int'(PROG_BASE[3]),
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 4095
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic [PC_W-1:0]  ProgCtr,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcLoadAddr,
  output logic             FetchEn,
  output logic             Ack,
  output logic             Timeout,
  output logic [1:0]       ProgIdx,
  output logic [CNT_W-1:0] CycleCount,
  output logic [PC_W-1:0]  LastPc
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_PROGS - 1);

  seq_state_t      r_state;
  logic            r_pc_load;
  logic            r_fetch_en;
  logic            r_ack;
  logic            r_timeout;
  logic [1:0]      r_prog_idx;
  logic [PC_W-1:0] r_last_pc;
  logic [PC_W-1:0] w_base;
  logic            w_cnt_clear;
  logic            w_cnt_en;
  logic            w_wdog;

  assign w_cnt_clear = (r_state == LOAD);
  assign w_cnt_en    = (r_state == RUN);

  run_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_run_counter (
    .i_clk     (Clk),
    .i_rst     (Reset),
    .i_clear   (w_cnt_clear),
    .i_en      (w_cnt_en),
    .o_count   (CycleCount),
    .o_timeout (w_wdog)
  );

  // Base address lookup for the selected program.
  always_comb begin
    w_base = PC_W'(PROG_BASE0);
    case (r_prog_idx)
      2'd0:    w_base = PC_W'(PROG_BASE0);
      2'd1:    w_base = PC_W'(PROG_BASE1);
      2'd2:    w_base = PC_W'(PROG_BASE2);
      2'd3:    w_base = PC_W'(PROG_BASE3);
      default: w_base = PC_W'(PROG_BASE0);
    endcase
  end

  // Sequencer FSM; outputs are set on the transition into the state that owns them.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_pc_load  <= 1'b0;
      r_fetch_en <= 1'b0;
      r_ack      <= 1'b0;
      r_timeout  <= 1'b0;
      r_prog_idx <= 2'd0;
      r_last_pc  <= '0;
    end else begin
      r_pc_load <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_state <= ARMED;
          end
        end
        ARMED: begin
          if (!Start) begin
            r_state   <= LOAD;
            r_pc_load <= 1'b1;
          end
        end
        LOAD: begin
          r_state    <= RUN;
          r_fetch_en <= 1'b1;
          r_ack      <= 1'b0;
          r_timeout  <= 1'b0;
        end
        RUN: begin
          // Halt beats the watchdog when both land on the same cycle.
          if (Halt) begin
            r_state    <= DONE;
            r_fetch_en <= 1'b0;
            r_ack      <= 1'b1;
            r_timeout  <= 1'b0;
            r_last_pc  <= ProgCtr;
          end else if (w_wdog) begin
            r_state    <= DONE;
            r_fetch_en <= 1'b0;
            r_ack      <= 1'b1;
            r_timeout  <= 1'b1;
            r_last_pc  <= ProgCtr;
          end else if (Start) begin
            r_state    <= ARMED;
            r_fetch_en <= 1'b0;
          end
        end
        DONE: begin
          if (Start) begin
            r_state    <= ARMED;
            r_ack      <= 1'b0;
            r_prog_idx <= (r_prog_idx >= LAST_IDX) ? 2'd0 : r_prog_idx + 2'd1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_fetch_en <= 1'b0;
          r_ack      <= 1'b0;
          r_timeout  <= 1'b0;
        end
      endcase
    end
  end

  assign PcLoad     = r_pc_load;
  assign PcLoadAddr = w_base;
  assign FetchEn    = r_fetch_en;
  assign Ack        = r_ack;
  assign Timeout    = r_timeout;
  assign ProgIdx    = r_prog_idx;
  assign LastPc     = r_last_pc;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench: a default-limit instance and a TIMEOUT=20 instance, each with a fetcher model.
module tb_prog_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, halt_a = 1'b0, start_b = 1'b0, halt_b = 1'b0;
  logic [9:0]  pc_a, pc_b, addr_a, addr_b, last_a, last_b;
  logic        pc_load_a, pc_load_b, fetch_a, fetch_b, ack_a, ack_b, to_a, to_b;
  logic [1:0]  idx_a, idx_b;
  logic [15:0] cnt_a, cnt_b;
  logic        ack_a_d = 1'b0, ack_b_d = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] cnt;
    logic        to;
    logic [9:0]  lpc;
  } res_t;

  res_t       res_q_a[$];
  res_t       res_q_b[$];
  logic [9:0] load_q_a[$];
  logic [9:0] load_q_b[$];

  prog_sequencer dut_a (
    .Clk(clk), .Reset(rst), .Start(start_a), .Halt(halt_a), .ProgCtr(pc_a),
    .PcLoad(pc_load_a), .PcLoadAddr(addr_a), .FetchEn(fetch_a), .Ack(ack_a),
    .Timeout(to_a), .ProgIdx(idx_a), .CycleCount(cnt_a), .LastPc(last_a)
  );

  prog_sequencer #(.TIMEOUT(20)) dut_b (
    .Clk(clk), .Reset(rst), .Start(start_b), .Halt(halt_b), .ProgCtr(pc_b),
    .PcLoad(pc_load_b), .PcLoadAddr(addr_b), .FetchEn(fetch_b), .Ack(ack_b),
    .Timeout(to_b), .ProgIdx(idx_b), .CycleCount(cnt_b), .LastPc(last_b)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) pc_a <= '0;
    else if (pc_load_a) pc_a <= addr_a;
    else if (fetch_a) pc_a <= pc_a + 10'd1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) pc_b <= '0;
    else if (pc_load_b) pc_b <= addr_b;
    else if (fetch_b) pc_b <= pc_b + 10'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: PcLoad pulses and completed programs.
  always @(negedge clk) begin
    if (!rst && pc_load_a) begin
      if (load_q_a.size() == 0) chk("pcload_a_unexpected", 32'(pc_load_a), 32'd0);
      else chk("pcload_addr_a", 32'(addr_a), 32'(load_q_a.pop_front()));
    end
    if (!rst && pc_load_b) begin
      if (load_q_b.size() == 0) chk("pcload_b_unexpected", 32'(pc_load_b), 32'd0);
      else chk("pcload_addr_b", 32'(addr_b), 32'(load_q_b.pop_front()));
    end
    if (!rst && ack_a && !ack_a_d) begin
      if (res_q_a.size() == 0) chk("ack_a_unexpected", 32'(ack_a), 32'd0);
      else begin
        res_t r;
        r = res_q_a.pop_front();
        chk("sb_idx_a", 32'(idx_a), 32'(r.idx));
        chk("sb_cnt_a", 32'(cnt_a), 32'(r.cnt));
        chk("sb_to_a", 32'(to_a), 32'(r.to));
        chk("sb_lastpc_a", 32'(last_a), 32'(r.lpc));
      end
    end
    if (!rst && ack_b && !ack_b_d) begin
      if (res_q_b.size() == 0) chk("ack_b_unexpected", 32'(ack_b), 32'd0);
      else begin
        res_t r;
        r = res_q_b.pop_front();
        chk("sb_idx_b", 32'(idx_b), 32'(r.idx));
        chk("sb_cnt_b", 32'(cnt_b), 32'(r.cnt));
        chk("sb_to_b", 32'(to_b), 32'(r.to));
        chk("sb_lastpc_b", 32'(last_b), 32'(r.lpc));
      end
    end
    ack_a_d <= ack_a;
    ack_b_d <= ack_b;
  end

  // One program on dut_a: Start high 3 cycles, release, halt on RUN cycle n.
  task automatic run_a(input int n, input logic [9:0] base, input logic [1:0] idx);
    res_t r;
    start_a = 1'b1;
    tick();
    chk("ack_drop_a", 32'(ack_a), 32'd0);
    tick();
    tick();
    start_a = 1'b0;
    load_q_a.push_back(base);
    tick();
    chk("load_pulse_a", 32'(pc_load_a), 32'd1);
    chk("load_nofetch_a", 32'(fetch_a), 32'd0);
    tick();
    chk("run_fetch_a", 32'(fetch_a), 32'd1);
    chk("run_noload_a", 32'(pc_load_a), 32'd0);
    r.idx = idx; r.cnt = 16'(n); r.to = 1'b0; r.lpc = base + 10'(n - 1);
    res_q_a.push_back(r);
    repeat (n - 1) tick();
    halt_a = 1'b1;
    tick();
    halt_a = 1'b0;
    chk("done_ack_a", 32'(ack_a), 32'd1);
    chk("done_cnt_a", 32'(cnt_a), 32'(n));
    chk("done_fetch_a", 32'(fetch_a), 32'd0);
    chk("done_to_a", 32'(to_a), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    res_t r;
    repeat (2) tick();
    chk("rst_pcload", 32'(pc_load_a), 32'd0);
    chk("rst_fetch", 32'(fetch_a), 32'd0);
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    chk("rst_idx", 32'(idx_a), 32'd0);
    rst = 1'b0;
    tick();

    // Halt while IDLE has no effect.
    halt_a = 1'b1;
    tick();
    halt_a = 1'b0;
    tick();
    chk("idle_halt_fetch", 32'(fetch_a), 32'd0);
    chk("idle_halt_ack", 32'(ack_a), 32'd0);

    run_a(10, 10'd0, 2'd0);

    // Halt while DONE has no effect.
    halt_a = 1'b1;
    tick();
    halt_a = 1'b0;
    tick();
    chk("done_halt_ack", 32'(ack_a), 32'd1);
    chk("done_halt_cnt", 32'(cnt_a), 32'd10);

    run_a(5, 10'd256, 2'd1);
    run_a(7, 10'd512, 2'd2);
    run_a(4, 10'd0, 2'd0);

    // Abort during RUN and restart the same program.
    start_a = 1'b1;
    repeat (3) tick();
    start_a = 1'b0;
    load_q_a.push_back(10'd256);
    tick();
    tick();
    repeat (4) tick();
    start_a = 1'b1;
    tick();
    chk("abort_fetch", 32'(fetch_a), 32'd0);
    chk("abort_idx", 32'(idx_a), 32'd1);
    chk("abort_ack", 32'(ack_a), 32'd0);
    halt_a = 1'b1;
    tick();
    halt_a = 1'b0;
    chk("armed_halt_fetch", 32'(fetch_a), 32'd0);
    chk("armed_halt_ack", 32'(ack_a), 32'd0);
    start_a = 1'b0;
    load_q_a.push_back(10'd256);
    tick();
    chk("reload_pulse", 32'(pc_load_a), 32'd1);
    chk("reload_addr", 32'(addr_a), 32'd256);
    tick();
    chk("reload_fetch", 32'(fetch_a), 32'd1);
    r.idx = 2'd1; r.cnt = 16'd6; r.to = 1'b0; r.lpc = 10'd261;
    res_q_a.push_back(r);
    repeat (5) tick();
    halt_a = 1'b1;
    tick();
    halt_a = 1'b0;
    chk("restart_cnt", 32'(cnt_a), 32'd6);

    // Watchdog on dut_b: 21 RUN cycles with no Halt.
    start_b = 1'b1;
    repeat (3) tick();
    start_b = 1'b0;
    load_q_b.push_back(10'd0);
    tick();
    tick();
    r.idx = 2'd0; r.cnt = 16'd21; r.to = 1'b1; r.lpc = 10'd20;
    res_q_b.push_back(r);
    repeat (20) tick();
    chk("wdog_not_yet", 32'(ack_b), 32'd0);
    tick();
    chk("wdog_ack", 32'(ack_b), 32'd1);
    chk("wdog_to", 32'(to_b), 32'd1);
    chk("wdog_cnt", 32'(cnt_b), 32'd21);
    chk("wdog_lastpc", 32'(last_b), 32'd20);
    chk("wdog_fetch", 32'(fetch_b), 32'd0);

    // Halt coincident with the watchdog limit: Halt wins.
    start_b = 1'b1;
    repeat (3) tick();
    start_b = 1'b0;
    load_q_b.push_back(10'd256);
    tick();
    tick();
    chk("run_to_cleared_b", 32'(to_b), 32'd0);
    r.idx = 2'd1; r.cnt = 16'd21; r.to = 1'b0; r.lpc = 10'd276;
    res_q_b.push_back(r);
    repeat (20) tick();
    halt_b = 1'b1;
    tick();
    halt_b = 1'b0;
    chk("tie_ack", 32'(ack_b), 32'd1);
    chk("tie_to", 32'(to_b), 32'd0);

    // Asynchronous reset mid-RUN at CycleCount=37.
    start_a = 1'b1;
    repeat (3) tick();
    start_a = 1'b0;
    load_q_a.push_back(10'd512);
    tick();
    tick();
    repeat (37) tick();
    chk("pre_rst_cnt", 32'(cnt_a), 32'd37);
    chk("pre_rst_idx", 32'(idx_a), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(cnt_a), 32'd0);
    chk("arst_fetch", 32'(fetch_a), 32'd0);
    chk("arst_idx", 32'(idx_a), 32'd0);
    chk("arst_ack_b", 32'(ack_b), 32'd0);
    chk("arst_lastpc_b", 32'(last_b), 32'd0);
    chk("arst_pcload", 32'(pc_load_a), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_pcload", 32'(pc_load_a), 32'd0);
    chk("post_rst_fetch", 32'(fetch_a), 32'd0);

    chk("loadq_a_empty", 32'(load_q_a.size()), 32'd0);
    chk("loadq_b_empty", 32'(load_q_b.size()), 32'd0);
    chk("resq_a_empty", 32'(res_q_a.size()), 32'd0);
    chk("resq_b_empty", 32'(res_q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
